// File: rtl/i2c_slave_shift_ctrl.sv
// i2c_slave_shift_ctrl: I2C slave byte engine. Combines the shift register,
// bit counter and ACK-slot sequencing, driven by SCL edge and START/STOP
// pulses that are already synchronised to pclk.
// Optional build macro I2C_SLAVE_GENERAL_CALL_EN: also answer the all-zero
// general-call write address and report it on the extra gc_hit output.
module i2c_slave_shift_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  start_det,
   input  logic                  stop_det,
   input  logic                  scl_rise,
   input  logic                  scl_fall,
   input  logic                  sda_in,
   input  logic [ADDR_WIDTH-1:0] slave_addr,
   input  logic                  ack_en,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  tx_req,
   output logic                  addr_hit,
   output logic                  rw_bit,
   output logic                  sda_drive_low,
   output logic                  busy
`ifdef I2C_SLAVE_GENERAL_CALL_EN
   ,
   output logic                  gc_hit
`endif
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
   } state_t;

   state_t                state_reg, state_next;
   logic [DATA_WIDTH-1:0] shifter_reg, shifter_next;
   logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
   logic [DATA_WIDTH-1:0] rx_data_reg, rx_data_next;
   logic                  rx_valid_reg, rx_valid_next;
   logic                  tx_req_reg, tx_req_next;
   logic                  addr_hit_reg, addr_hit_next;
   logic                  rw_bit_reg, rw_bit_next;
   logic                  sda_low_reg, sda_low_next;
   logic                  mack_reg, mack_next;      // sampled master ACK bit (1 = NACK)
`ifdef I2C_SLAVE_GENERAL_CALL_EN
   logic                  gc_hit_reg, gc_hit_next;
`endif

   // A simultaneous rise and fall is illegal; the rise wins.
   logic scl_fall_eff;
   assign scl_fall_eff = scl_fall & ~scl_rise;

   // Bitwise compare of the received address field against our own address.
   logic [ADDR_WIDTH-1:0] addr_eq;
   logic                  addr_match;
   for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr_cmp
      assign addr_eq[gi] = (shifter_reg[DATA_WIDTH-ADDR_WIDTH+gi] == slave_addr[gi]);
   end
   assign addr_match = &addr_eq;

   // Next-state and datapath decode; STOP beats START beats SCL edges.
   always_comb begin
      state_next    = state_reg;
      shifter_next  = shifter_reg;
      bit_cnt_next  = bit_cnt_reg;
      rx_data_next  = rx_data_reg;
      rx_valid_next = 1'b0;
      tx_req_next   = 1'b0;
      addr_hit_next = addr_hit_reg;
      rw_bit_next   = rw_bit_reg;
      sda_low_next  = sda_low_reg;
      mack_next     = mack_reg;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
      gc_hit_next   = gc_hit_reg;
`endif
      if (stop_det) begin
         state_next    = IDLE;
         addr_hit_next = 1'b0;
         sda_low_next  = 1'b0;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
         gc_hit_next   = 1'b0;
`endif
      end else if (start_det) begin
         state_next    = ADDR;
         bit_cnt_next  = '0;
         addr_hit_next = 1'b0;
         sda_low_next  = 1'b0;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
         gc_hit_next   = 1'b0;
`endif
      end else begin
         case (state_reg)
            ADDR, RX: begin
               if (scl_rise && bit_cnt_reg != CNT_FULL) begin
                  shifter_next = {shifter_reg[DATA_WIDTH-2:0], sda_in};
                  bit_cnt_next = bit_cnt_reg + CNT_W'(1);
               end else if (scl_fall_eff && bit_cnt_reg == CNT_FULL) begin
                  if (state_reg == ADDR) begin
                     state_next   = ADDR_ACK;
                     sda_low_next = 1'b0;
                     if (addr_match) begin
                        addr_hit_next = 1'b1;
                        rw_bit_next   = shifter_reg[0];
                        sda_low_next  = 1'b1;
                     end
`ifdef I2C_SLAVE_GENERAL_CALL_EN
                     else if (shifter_reg == '0) begin
                        addr_hit_next = 1'b1;
                        gc_hit_next   = 1'b1;
                        rw_bit_next   = 1'b0;
                        sda_low_next  = 1'b1;
                     end
`endif
                  end else begin
                     state_next    = RX_ACK;
                     rx_data_next  = shifter_reg;
                     rx_valid_next = 1'b1;
                     sda_low_next  = ack_en;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall_eff) begin
                  bit_cnt_next = '0;
                  sda_low_next = 1'b0;
                  if (!addr_hit_reg) begin
                     state_next = WAIT_STOP;
                  end else if (!rw_bit_reg) begin
                     state_next = RX;
                  end else begin
                     state_next   = TX;
                     tx_req_next  = 1'b1;
                     shifter_next = tx_data;
                     sda_low_next = ~tx_data[DATA_WIDTH-1];
                  end
               end
            end
            RX_ACK: begin
               if (scl_fall_eff) begin
                  state_next   = RX;
                  sda_low_next = 1'b0;
                  bit_cnt_next = '0;
               end
            end
            TX: begin
               if (scl_rise && bit_cnt_reg != CNT_FULL) begin
                  bit_cnt_next = bit_cnt_reg + CNT_W'(1);
               end else if (scl_fall_eff) begin
                  if (bit_cnt_reg == CNT_FULL) begin
                     state_next   = TX_ACK;
                     sda_low_next = 1'b0;
                     mack_next    = 1'b1;
                  end else begin
                     shifter_next = {shifter_reg[DATA_WIDTH-2:0], 1'b0};
                     sda_low_next = ~shifter_reg[DATA_WIDTH-2];
                  end
               end
            end
            TX_ACK: begin
               if (scl_rise) begin
                  mack_next = sda_in;
               end else if (scl_fall_eff) begin
                  bit_cnt_next = '0;
                  if (!mack_reg) begin
                     state_next   = TX;
                     tx_req_next  = 1'b1;
                     shifter_next = tx_data;
                     sda_low_next = ~tx_data[DATA_WIDTH-1];
                  end else begin
                     state_next   = WAIT_STOP;
                     sda_low_next = 1'b0;
                  end
               end
            end
            WAIT_STOP: sda_low_next = 1'b0;
            IDLE:      sda_low_next = 1'b0;
            default:   state_next   = IDLE;
         endcase
      end
   end

   // State and output registers; reset releases SDA immediately.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_reg    <= IDLE;
         shifter_reg  <= '0;
         bit_cnt_reg  <= '0;
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         tx_req_reg   <= 1'b0;
         addr_hit_reg <= 1'b0;
         rw_bit_reg   <= 1'b0;
         sda_low_reg  <= 1'b0;
         mack_reg     <= 1'b1;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
         gc_hit_reg   <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         shifter_reg  <= shifter_next;
         bit_cnt_reg  <= bit_cnt_next;
         rx_data_reg  <= rx_data_next;
         rx_valid_reg <= rx_valid_next;
         tx_req_reg   <= tx_req_next;
         addr_hit_reg <= addr_hit_next;
         rw_bit_reg   <= rw_bit_next;
         sda_low_reg  <= sda_low_next;
         mack_reg     <= mack_next;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
         gc_hit_reg   <= gc_hit_next;
`endif
      end
   end

   assign rx_data       = rx_data_reg;
   assign rx_valid      = rx_valid_reg;
   assign tx_req        = tx_req_reg;
   assign addr_hit      = addr_hit_reg;
   assign rw_bit        = rw_bit_reg;
   assign sda_drive_low = sda_low_reg;
   assign busy          = (state_reg != IDLE);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
   assign gc_hit        = gc_hit_reg;
`endif

endmodule

// File: doc/i2c_slave_shift_ctrl.md
Name: i2c_slave_shift_ctrl

Overview:
Parametrised next-generation I2C slave byte engine. Merges the shift register, bit counter and ACK-slot sequencing into one block. Driven by SCL-edge and START/STOP pulses from the bus front-end in the pclk domain. Performs address match, receive/transmit shifting, slave ACK generation and master-ACK sampling, and presents byte-level handshakes to the register/APB side.

Parameters:
DATA_WIDTH, 8, bits per transfer byte; ≥ 2.
ADDR_WIDTH, 7, slave address bits; must satisfy ADDR_WIDTH ≤ DATA_WIDTH-1. Compared against rx bits [DATA_WIDTH-1 -: ADDR_WIDTH]. R/W is bit 0.

Ports:
pclk  input  1  system clock
presetn  input  1  reset; asynchronous, active-low
start_det  input  1  one-cycle pulse: START or repeated START detected
stop_det  input  1  one-cycle pulse: STOP detected
scl_rise  input  1  one-cycle pulse: SCL rising edge (sample point)
scl_fall  input  1  one-cycle pulse: SCL falling edge (drive point)
sda_in  input  1  synchronised SDA
slave_addr  input  ADDR_WIDTH  own address
ack_en  input  1  1 = ACK received data bytes, 0 = NACK them
tx_data  input  DATA_WIDTH  next transmit byte, loaded on tx_req cycle
rx_data  output  DATA_WIDTH  last received data byte
rx_valid  output  1  one-cycle pulse: rx_data updated
tx_req  output  1  one-cycle pulse: tx_data captured this cycle
addr_hit  output  1  level: addressed in current transfer
rw_bit  output  1  level: R/W bit of matched address byte
sda_drive_low  output  1  1 = pull SDA low (open-drain)
busy  output  1  level: state != IDLE

Behaviour:
- Reset: all outputs 0. FSM = IDLE. Shift register = 0. bit_cnt = 0.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- Event priority per cycle: stop_det > start_det > scl edges.
- stop_det in any state -> IDLE; clear addr_hit, release SDA.
- start_det in any state -> ADDR; clear bit_cnt and addr_hit; release SDA.
- ADDR/RX, on scl_rise: shift_reg <= {shift_reg[DATA_WIDTH-2:0], sda_in}; bit_cnt++.
- After the DATA_WIDTH-th sample, the next scl_fall enters the ACK state.
  - ADDR -> ADDR_ACK: on match, set addr_hit and capture rw_bit = shift_reg[0]; sda_drive_low = 1. No match: SDA released.
  - RX -> RX_ACK: rx_data <= shift_reg; rx_valid pulses in the same cycle; sda_drive_low = ack_en.
- ADDR_ACK, next scl_fall:
  - No match -> WAIT_STOP.
  - rw_bit = 0 -> RX.
  - rw_bit = 1 -> TX: tx_req pulses, tx_data loaded, sda_drive_low = ~tx_data[DATA_WIDTH-1].
- RX_ACK, next scl_fall: -> RX; SDA released; bit_cnt = 0.
- TX, each scl_fall: shift left, drive next MSB.
  - After DATA_WIDTH bits, the scl_fall releases SDA -> TX_ACK.
  - bit_cnt counts scl_rise events.
- TX_ACK, on scl_rise: sample master ack (sda_in).
  - Next scl_fall with ACK (0): tx_req pulse, load, drive MSB -> TX.
  - Next scl_fall with NACK (1): -> WAIT_STOP, SDA released.
- WAIT_STOP: SDA released. Ignores scl edges. Leaves only on stop_det/start_det.
- scl_rise and scl_fall asserted in the same cycle is illegal. Block treats it as scl_rise only.
- Reset asserted mid-byte: immediate return to reset values, SDA released asynchronously.
- Latency: every output update is registered, one pclk after the qualifying pulse.

Optional Feature:
Macro I2C_SLAVE_GENERAL_CALL_EN.
- Defined: an address byte of all zeros with R/W = 0 also matches. addr_hit = 1, ACKed, enters RX. Extra output gc_hit (1 bit, reset 0) is set with addr_hit and cleared with it.
- Undefined: port absent; only slave_addr matches.

Test Plan:
- slave_addr=7'h3C. START, shift 0x78 (write), then 0xA5 with ack_en=1 -> addr_hit=1 and sda_drive_low=1 in both ACK slots; rx_data=0xA5 with one rx_valid pulse; STOP -> busy=0.
- START, shift 0x79 (read), tx_data=0x5A, master ACK, then tx_data=0xC3, master NACK -> SDA bit sequence 0,1,0,1,1,0,1,0 then 1,1,0,0,0,0,1,1; two tx_req pulses; WAIT_STOP reached.
- START, address 0x52 (no match) -> no SDA pull in ACK slot; state WAIT_STOP; following data byte ignored (no rx_valid).
- Write with ack_en=0 on byte 0x11 -> rx_valid pulses, rx_data=0x11, SDA released in ACK slot.
- Repeated START after 4 data bits, then 0x79 -> clean re-address, rw_bit=1; presetn low mid-TX -> sda_drive_low=0 same cycle, all outputs 0.
- With I2C_SLAVE_GENERAL_CALL_EN: address byte 0x00 -> gc_hit=1, ACK; without macro -> NACK, WAIT_STOP.
